spi_slave_rx_mode3: RTL and testbench

SPI_SLAVE_RX_MODE3 -- requirements
Module: spi_slave_rx_mode3

---
 rtl/spi_slave_rx_mode3.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_rx_mode3.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 receive-only slave: synchronizes CS/SCLK/MOSI into In_clk,
// shifts MSB-first bytes on SCLK rises and reports them with a valid pulse.
//
// Ports:
//   In_clk        system clock, rising edge
//   In_rst        asynchronous active-high reset
//   In_spi_cs_n   SPI chip select, active low (asynchronous)
//   In_spi_sclk   SPI clock, mode 3, idle high (asynchronous)
//   In_spi_mosi   SPI data from master (asynchronous)
//   Out_rx_data   last completed byte
//   Out_rx_valid  one-cycle pulse when Out_rx_data is updated
//   Out_rx_busy   high while a CS-low frame is being received
//   Out_frame_err one-cycle pulse when a partial byte is aborted by CS rise
//   Out_rx_cnt    bytes received since reset, wraps at 256
module spi_slave_rx_mode3 #(
    parameter int REF_CLK  = 50_000_000,
    parameter int SPI_SCLK = 500_000
) (
    input  logic       In_clk,
    input  logic       In_rst,
    input  logic       In_spi_cs_n,
    input  logic       In_spi_sclk,
    input  logic       In_spi_mosi,
    output logic [7:0] Out_rx_data,
    output logic       Out_rx_valid,
    output logic       Out_rx_busy,
    output logic       Out_frame_err,
    output logic [7:0] Out_rx_cnt
);

    // Oversampling ratio; the edge detector needs several In_clk
    // cycles per SCLK phase to see every transition.
    localparam int RATIO = REF_CLK / SPI_SCLK;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t state_q, state_d;

    // cs_n/sclk idle high, so their flops reset high to avoid a
    // phantom edge right after reset release.
    logic cs_s1_q, cs_s2_q, cs_d_q;
    logic sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic mosi_s1_q, mosi_s2_q;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    always_ff @(posedge In_clk or posedge In_rst) begin
        if (In_rst) begin
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_d_q    <= 1'b1;
            sclk_s1_q <= 1'b1;
            sclk_s2_q <= 1'b1;
            sclk_d_q  <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= In_spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_d_q    <= cs_s2_q;
            sclk_s1_q <= In_spi_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d_q  <= sclk_s2_q;
            mosi_s1_q <= In_spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Only rising SCLK matters: the master changes MOSI on falls.
    assign sclk_rise = sclk_s2_q & ~sclk_d_q;
    assign cs_fall   = ~cs_s2_q & cs_d_q;
    assign cs_rise   = cs_s2_q & ~cs_d_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = RECV;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            RECV: begin
                if (cs_fall) begin
                    // Glitch on CS: restart the frame silently.
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end else begin
                    if (sclk_rise) begin
                        shift_d   = {shift_q[6:0], mosi_s2_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {shift_q[6:0], mosi_s2_q};
                            valid_d = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                        end
                    end
                    // Judge the abort on the post-shift count so a CS
                    // rise coinciding with the 8th SCLK rise delivers
                    // the byte instead of flagging an error.
                    if (cs_rise) begin
                        state_d = IDLE;
                        if (bit_cnt_d != 3'd0) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge In_clk or posedge In_rst) begin
        if (In_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Out_rx_data   = data_q;
    assign Out_rx_valid  = valid_q;
    assign Out_rx_busy   = (state_q == RECV);
    assign Out_frame_err = err_q;
    assign Out_rx_cnt    = cnt_q;

    a_ratio : assert property (@(posedge In_clk) RATIO >= 8);

    a_excl : assert property (
        @(posedge In_clk) disable iff (In_rst)
        !(Out_rx_valid && Out_frame_err)
    );

endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Bench for spi_slave_rx_mode3: byte-level scoreboard driven by a
// mode-3 master model, plus directed literal checks.
`timescale 1ns/1ps
module tb_spi_slave_rx_mode3;

    localparam int HP_SLOW = 1000;  // 500 kHz SCLK half period
    localparam int HP_FAST = 100;   // 5 MHz SCLK, ratio 10

    logic       In_clk;
    logic       In_rst;
    logic       In_spi_cs_n;
    logic       In_spi_sclk;
    logic       In_spi_mosi;
    logic [7:0] Out_rx_data;
    logic       Out_rx_valid;
    logic       Out_rx_busy;
    logic       Out_frame_err;
    logic [7:0] Out_rx_cnt;

    int vectors;
    int miscompares;

    logic [7:0] exp_q[$];
    logic [7:0] model_cnt;
    logic [7:0] last_data;
    int         pending_err;
    int         busy_mode;

    spi_slave_rx_mode3 #(
        .REF_CLK (50_000_000),
        .SPI_SCLK(5_000_000)
    ) dut (
        .In_clk       (In_clk),
        .In_rst       (In_rst),
        .In_spi_cs_n  (In_spi_cs_n),
        .In_spi_sclk  (In_spi_sclk),
        .In_spi_mosi  (In_spi_mosi),
        .Out_rx_data  (Out_rx_data),
        .Out_rx_valid (Out_rx_valid),
        .Out_rx_busy  (Out_rx_busy),
        .Out_frame_err(Out_frame_err),
        .Out_rx_cnt   (Out_rx_cnt)
    );

    initial begin
        In_clk = 1'b0;
        forever #10 In_clk = ~In_clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every byte the master completes must come out once,
    // in order; every aborted partial byte must raise one error pulse.
    always @(negedge In_clk) begin
        if (In_rst) begin
            chk("rst_data", Out_rx_data, 0);
            chk("rst_valid", Out_rx_valid, 0);
            chk("rst_busy", Out_rx_busy, 0);
            chk("rst_err", Out_frame_err, 0);
            chk("rst_cnt", Out_rx_cnt, 0);
        end else begin
            chk("valid_err_excl", Out_rx_valid & Out_frame_err, 0);
            if (Out_rx_valid) begin
                chk("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    last_data = exp_q.pop_front();
                    model_cnt = model_cnt + 8'd1;
                end
            end
            if (Out_frame_err) begin
                chk("err_expected", pending_err > 0, 1);
                if (pending_err > 0) pending_err--;
            end
            chk("data", Out_rx_data, last_data);
            chk("cnt", Out_rx_cnt, model_cnt);
            if (busy_mode == 1) chk("busy_high", Out_rx_busy, 1);
            if (busy_mode == 2) chk("busy_low", Out_rx_busy, 0);
        end
    end

    task automatic cs_low(input int hp);
        In_spi_cs_n = 1'b0;
        #(hp);
        busy_mode = 1;
    endtask

    task automatic cs_high(input int hp, input bit partial);
        busy_mode = 0;
        if (partial) pending_err++;
        In_spi_cs_n = 1'b1;
        #(2 * hp);
    endtask

    // Mode 3: data changes on the falling edge, sampled on the rise.
    task automatic clk_bits(input logic [7:0] b, input int n,
                            input int hp);
        for (int i = 0; i < n; i++) begin
            In_spi_sclk = 1'b0;
            In_spi_mosi = b[7-i];
            #(hp);
            In_spi_sclk = 1'b1;
            if (i == 7) exp_q.push_back(b);
            #(hp);
        end
    endtask

    task automatic frame(input logic [7:0] b, input int hp);
        cs_low(hp);
        clk_bits(b, 8, hp);
        cs_high(hp, 0);
    endtask

    task automatic do_reset();
        @(posedge In_clk);
        #1;
        busy_mode = 0;
        In_rst = 1'b1;
        model_cnt = 8'h00;
        last_data = 8'h00;
        exp_q.delete();
        pending_err = 0;
        #1;
        chk("imm_rst_data", Out_rx_data, 0);
        chk("imm_rst_valid", Out_rx_valid, 0);
        chk("imm_rst_busy", Out_rx_busy, 0);
        chk("imm_rst_err", Out_frame_err, 0);
        chk("imm_rst_cnt", Out_rx_cnt, 0);
        In_spi_cs_n = 1'b1;
        In_spi_sclk = 1'b1;
        In_spi_mosi = 1'b0;
        #100;
        In_rst = 1'b0;
        #100;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_cnt = 8'h00;
        last_data = 8'h00;
        pending_err = 0;
        busy_mode = 0;
        In_rst = 1'b1;
        In_spi_cs_n = 1'b1;
        In_spi_sclk = 1'b1;
        In_spi_mosi = 1'b0;
        #55;
        do_reset();

        // Three single-byte frames at 500 kHz.
        frame(8'h00, HP_SLOW);
        frame(8'h01, HP_SLOW);
        frame(8'h02, HP_SLOW);
        chk("t1_cnt", Out_rx_cnt, 3);
        chk("t1_data", Out_rx_data, 8'h02);

        // Two bytes back-to-back in one frame, busy held throughout.
        cs_low(HP_SLOW);
        clk_bits(8'hA5, 8, HP_SLOW);
        clk_bits(8'h3C, 8, HP_SLOW);
        cs_high(HP_SLOW, 0);
        chk("t2_data", Out_rx_data, 8'h3C);
        chk("t2_cnt", Out_rx_cnt, 5);

        // Abort after 5 bits, then a clean frame.
        cs_low(HP_SLOW);
        clk_bits(8'hF0, 5, HP_SLOW);
        cs_high(HP_SLOW, 1);
        chk("t3_err_data", Out_rx_data, 8'h3C);
        chk("t3_err_cnt", Out_rx_cnt, 5);
        frame(8'h7E, HP_SLOW);
        chk("t3_data", Out_rx_data, 8'h7E);
        chk("t3_cnt", Out_rx_cnt, 6);

        // Reset in the middle of 0xFF, then 0x81 with a latency probe.
        cs_low(HP_SLOW);
        clk_bits(8'hFF, 4, HP_SLOW);
        do_reset();
        cs_low(HP_SLOW);
        clk_bits(8'h81, 7, HP_SLOW);
        In_spi_sclk = 1'b0;
        In_spi_mosi = 1'b1;
        #(HP_SLOW);
        @(negedge In_clk);
        In_spi_sclk = 1'b1;
        exp_q.push_back(8'h81);
        for (int k = 1; k <= 3; k++) begin
            @(posedge In_clk);
            #1;
            chk($sformatf("lat_edge%0d", k), Out_rx_valid, k == 3);
        end
        #(HP_SLOW);
        cs_high(HP_SLOW, 0);
        chk("t5_data", Out_rx_data, 8'h81);
        chk("t5_cnt", Out_rx_cnt, 1);

        // SCLK activity with CS high must be ignored.
        busy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            In_spi_sclk = 1'b0;
            In_spi_mosi = i[0];
            #(HP_SLOW);
            In_spi_sclk = 1'b1;
            #(HP_SLOW);
        end
        busy_mode = 0;
        chk("t6_idle_cnt", Out_rx_cnt, 1);

        // CS rise simultaneous with the 8th SCLK rise.
        cs_low(HP_SLOW);
        clk_bits(8'h5A, 7, HP_SLOW);
        In_spi_sclk = 1'b0;
        In_spi_mosi = 1'b0;
        #(HP_SLOW);
        busy_mode = 0;
        In_spi_sclk = 1'b1;
        In_spi_cs_n = 1'b1;
        exp_q.push_back(8'h5A);
        #(2 * HP_SLOW);
        chk("t6_data", Out_rx_data, 8'h5A);
        chk("t6_cnt", Out_rx_cnt, 2);

        // 256 frames from reset: counter wraps on the last one.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            frame(i[7:0], HP_FAST);
            if (i == 254) chk("wrap_255", Out_rx_cnt, 8'hFF);
        end
        chk("wrap_0", Out_rx_cnt, 8'h00);
        chk("wrap_data", Out_rx_data, 8'hFF);

        #200;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("err_pending", pending_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
